// File: rtl/dmem_mmio_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_mmio_responder_if
//   Data-memory bus between the single-cycle core (master) and the memory /
//   MMIO responder (slave).
//
//   Protocol: there is no valid/ready pair. Every cycle the core presents an
//   address and access type, and the slave returns Data_out combinationally in
//   that same cycle. mem_w=1 marks a store that commits on the next rising
//   clock edge. Nothing is ever back-pressured.
//
//   Signals:
//     mem_w     core -> slave  store strobe
//     Addr_in   core -> slave  byte address
//     Data_in   core -> slave  store data
//     dm_ctrl   core -> slave  access type (word / half / byte, signedness)
//     Data_out  slave -> core  load data
// ---------------------------------------------------------------------------
interface dmem_mmio_responder_if;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [2:0]  dm_ctrl;
    logic [31:0] Data_out;

    modport master (output mem_w, Addr_in, Data_in, dm_ctrl, input Data_out);
    modport slave  (input mem_w, Addr_in, Data_in, dm_ctrl, output Data_out);
endinterface

// File: rtl/dmem_mmio_responder.sv
// ---------------------------------------------------------------------------
// dmem_mmio_responder
//   Responder end of the core's data-memory bus. Decodes each access into a
//   word-organised RAM or a small MMIO bank (LED, CYCLE counter, TCMP timer
//   compare, ISTAT interrupt status). Loads are combinational; stores commit
//   on the rising edge of clk.
//
//   Optional feature (macro DMEM_MISALIGN_TRAP_EN): a misaligned access sets
//   ISTAT bit1 (W1C) and raises INT. Without the macro, misaligned accesses
//   are silently dropped and bit1 reads 0.
//
//   Ports:
//     clk      system clock
//     reset    synchronous, active-high reset
//     bus      dmem_mmio_responder_if.slave (mem_w, Addr_in, Data_in,
//              dm_ctrl in; Data_out out)
//     led_out  LED register contents
//     INT      registered interrupt request to the core
//
//   No FSM: the block is a decoder plus a handful of registers.
// ---------------------------------------------------------------------------
module dmem_mmio_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [15:0] MMIO_HI     = 16'hFFFF
) (
    input  logic                          clk,
    input  logic                          reset,
    dmem_mmio_responder_if.slave          bus,
    output logic [15:0]                   led_out,
    output logic                          INT
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [15:0] led_q;
    logic [31:0] cycle_q;
    logic [31:0] tcmp_q;
    logic        timer_pend_q;
    logic        mis_pend_q;

    // Access decode
    logic          is_half, is_byte, is_word, is_signed, misaligned, is_mmio;
    logic [AW-1:0] ram_idx;
    logic [13:0]   mmio_word;

    always_comb begin
        is_half    = (bus.dm_ctrl == 3'b001) || (bus.dm_ctrl == 3'b010);
        is_byte    = (bus.dm_ctrl == 3'b011) || (bus.dm_ctrl == 3'b100);
        is_word    = !is_half && !is_byte;
        is_signed  = (bus.dm_ctrl == 3'b001) || (bus.dm_ctrl == 3'b011);
        misaligned = (is_word && (bus.Addr_in[1:0] != 2'b00)) ||
                     (is_half && bus.Addr_in[0]);
        is_mmio    = (bus.Addr_in[31:16] == MMIO_HI);
        ram_idx    = bus.Addr_in[AW+1:2];   // upper bits ignored: RAM aliases
        mmio_word  = bus.Addr_in[15:2];
    end

    // Read path: pick the word, then the lane
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_word = '0;
        if (is_mmio) begin
            // Word-granular decode so sub-word loads see lanes of the register
            case (mmio_word)
                14'd0:   rd_word = {16'h0000, led_q};
                14'd1:   rd_word = cycle_q;
                14'd2:   rd_word = tcmp_q;
                14'd3:   rd_word = {30'd0, mis_pend_q, timer_pend_q};
                default: rd_word = '0;
            endcase
        end else begin
            rd_word = mem[ram_idx];
        end

        rd_byte = rd_word[{bus.Addr_in[1:0], 3'b000} +: 8];
        rd_half = bus.Addr_in[1] ? rd_word[31:16] : rd_word[15:0];

        bus.Data_out = rd_word;
        if (is_byte)
            bus.Data_out = is_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
        else if (is_half)
            bus.Data_out = is_signed ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
        if (misaligned)
            bus.Data_out = '0;
    end

    // Store path: replicate data across lanes and enable only the addressed ones
    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic        ram_we, mmio_we, wr_led, wr_tcmp, wr_istat;

    always_comb begin
        if (is_byte) begin
            byte_en = 4'b0001 << bus.Addr_in[1:0];
            wr_data = {4{bus.Data_in[7:0]}};
        end else if (is_half) begin
            byte_en = bus.Addr_in[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.Data_in[15:0]}};
        end else begin
            byte_en = 4'b1111;
            wr_data = bus.Data_in;
        end
        // Reset wins over any store in the same cycle, RAM included
        ram_we   = bus.mem_w && !is_mmio && !misaligned && !reset;
        // MMIO accepts aligned word stores only
        mmio_we  = bus.mem_w && is_mmio && is_word && !misaligned;
        wr_led   = mmio_we && (mmio_word == 14'd0);
        wr_tcmp  = mmio_we && (mmio_word == 14'd2);
        wr_istat = mmio_we && (mmio_word == 14'd3);
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // MMIO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q        <= '0;
            cycle_q      <= '0;
            tcmp_q       <= 32'hFFFF_FFFF;
            timer_pend_q <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (wr_led)
                led_q <= bus.Data_in[15:0];
            if (wr_tcmp)
                tcmp_q <= bus.Data_in;
            // Registered compare; a set in the same cycle as a W1C wins
            timer_pend_q <= (cycle_q == tcmp_q) ||
                            (timer_pend_q && !(wr_istat && bus.Data_in[0]));
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset)
            mis_pend_q <= 1'b0;
        else
            mis_pend_q <= misaligned ||
                          (mis_pend_q && !(wr_istat && bus.Data_in[1]));
    end
`else
    assign mis_pend_q = 1'b0;
`endif

    // Both terms are flops, so INT has no combinational path from the bus
    assign INT     = timer_pend_q | mis_pend_q;
    assign led_out = led_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_LED   = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE = 32'hFFFF_0004;
  localparam logic [31:0] A_TCMP  = 32'hFFFF_0008;
  localparam logic [31:0] A_ISTAT = 32'hFFFF_000C;
  localparam logic [2:0]  C_W  = 3'b000;
  localparam logic [2:0]  C_HS = 3'b001;
  localparam logic [2:0]  C_HU = 3'b010;
  localparam logic [2:0]  C_BS = 3'b011;
  localparam logic [2:0]  C_BU = 3'b100;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [15:0] led_out;
  logic int_o;

  always #5 clk = ~clk;

  dmem_mmio_responder_if bus();

  dmem_mmio_responder dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .led_out (led_out),
    .INT     (int_o)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        sb_chk;
  int          n_checks;
  int          n_fail;
  int          next_cycle;

  always @(negedge clk) begin
    if (sb_chk) begin
      logic [31:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (bus.Data_out !== e) begin
        n_fail++;
        $display("FAIL %s: Data_out got %h expected %h", nm, bus.Data_out, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] c, input logic chk, input logic [31:0] e,
                     input string nm);
    @(posedge clk); #1;
    reset       = 1'b0;
    bus.mem_w   = w;
    bus.Addr_in = a;
    bus.Data_in = d;
    bus.dm_ctrl = c;
    sb_chk      = chk;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    next_cycle++;
  endtask

  task automatic rst_cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reset       = 1'b1;
    bus.mem_w   = w;
    bus.Addr_in = a;
    bus.Data_in = d;
    bus.dm_ctrl = C_W;
    sb_chk      = 1'b0;
    next_cycle  = 0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    cyc(1'b1, a, d, c, 1'b0, 32'h0, "");
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] c, input logic [31:0] e,
                    input string nm);
    cyc(1'b0, a, 32'h0, c, 1'b1, e, nm);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_cyc(1'b0, 32'h0, 32'h0);
    st(A_LED, 32'h0000_5A5A, C_W);
    ld(A_LED, C_W, 32'h0000_5A5A, "led_readback");
    @(negedge clk);
    n_checks++;
    if (led_out !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL led_set: led_out got %h expected 5a5a", led_out);
    end
    // Reset held with a concurrent LED store: reset must win
    rst_cyc(1'b1, A_LED, 32'h0000_FFFF);
    ld(A_CYCLE, C_W, 32'd0, "cycle_after_reset");
    @(negedge clk);
    n_checks++;
    if (led_out !== 16'h0000 || int_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: led_out=%h INT=%b expected 0000 0", led_out, int_o);
    end
    for (int k = 1; k <= 3; k++) ld(A_CYCLE, C_W, 32'(k), "cycle_count");
    ld(A_TCMP, C_W, 32'hFFFF_FFFF, "tcmp_reset");
    ld(A_ISTAT, C_W, 32'h0, "istat_reset");
  endtask

  task automatic test_ram_lanes;
    st(32'h100, 32'h1234_5678, C_W);
    ld(32'h103, C_BS, 32'h0000_0012, "byte_s_103");
    ld(32'h102, C_HU, 32'h0000_1234, "half_u_102");
    ld(32'h100, C_W, 32'h1234_5678, "word_100");
    st(32'h101, 32'h0000_00AB, C_BS);
    ld(32'h100, C_W, 32'h1234_AB78, "word_after_byte_st");
    ld(32'h101, C_BS, 32'hFFFF_FFAB, "byte_s_101");
    ld(32'h101, C_BU, 32'h0000_00AB, "byte_u_101");
    ld(32'h100, C_HS, 32'hFFFF_AB78, "half_s_100");
    ld(32'h1100, C_W, 32'h1234_AB78, "alias_1100");
    st(32'h200, 32'h1122_3344, C_W);
    // Store and load to the same word in one cycle returns the old data
    cyc(1'b1, 32'h200, 32'hCAFE_F00D, C_W, 1'b1, 32'h1122_3344, "same_cycle_old");
    ld(32'h200, C_W, 32'hCAFE_F00D, "same_cycle_new");
    st(32'h202, 32'h0000_5566, C_HU);
    ld(32'h200, C_W, 32'h5566_F00D, "half_st_word");
    ld(32'h202, C_HS, 32'h0000_5566, "half_s_202");
    ld(32'h203, C_BU, 32'h0000_0055, "byte_u_203");
  endtask

  task automatic test_back_to_back;
    logic [31:0] model [8];
    for (int i = 0; i < 8; i++) begin
      model[i] = {$urandom_range(65535, 0), $urandom_range(65535, 0)};
      st(32'h400 + 32'(i * 4), model[i], C_W);
    end
    for (int i = 0; i < 8; i++) ld(32'h400 + 32'(i * 4), C_W, model[i], "b2b_word");
  endtask

  task automatic test_timer;
    rst_cyc(1'b0, 32'h0, 32'h0);
    st(A_TCMP, 32'd20, C_W);                     // cycle 0
    for (int k = 1; k <= 24; k++) begin
      ld(A_CYCLE, C_W, 32'(k), "timer_cycle");
      @(negedge clk);
      n_checks++;
      if (int_o !== (k >= 21)) begin
        n_fail++;
        $display("FAIL timer_int cycle %0d: INT got %b expected %b", k, int_o, (k >= 21));
      end
    end
    st(A_ISTAT, 32'h1, C_W);                     // cycle 25: W1C
    @(negedge clk);
    n_checks++;
    if (int_o !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_same_cycle_int: INT got %b expected 1", int_o);
    end
    ld(A_CYCLE, C_W, 32'd26, "timer_cycle");     // cycle 26
    @(negedge clk);
    n_checks++;
    if (int_o !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_cleared: INT got %b expected 0", int_o);
    end
    st(A_TCMP, 32'd30, C_W);                     // cycle 27
    ld(A_CYCLE, C_W, 32'd28, "timer_cycle");
    ld(A_CYCLE, C_W, 32'd29, "timer_cycle");
    st(A_ISTAT, 32'h1, C_W);                     // cycle 30: clear vs set
    @(negedge clk);
    n_checks++;
    if (int_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_set_int: INT got %b expected 0", int_o);
    end
    ld(A_ISTAT, C_W, 32'h1, "set_wins_istat");   // cycle 31
    @(negedge clk);
    n_checks++;
    if (int_o !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins_int: INT got %b expected 1", int_o);
    end
  endtask

  task automatic test_misalign;
    rst_cyc(1'b0, 32'h0, 32'h0);
    st(32'h102, 32'hDEAD_BEEF, C_W);
    ld(32'h100, C_W, 32'h1234_AB78, "misaligned_st_ignored");
    @(negedge clk);
    n_checks++;
    if (int_o !== TRAP) begin
      n_fail++;
      $display("FAIL misalign_int: INT got %b expected %b", int_o, TRAP);
    end
    ld(A_ISTAT, C_W, {30'd0, TRAP, 1'b0}, "misalign_istat");
    ld(32'h102, C_W, 32'h0, "misaligned_word_ld");
    ld(32'h101, C_HS, 32'h0, "misaligned_half_ld");
    st(A_ISTAT, 32'h2, C_W);
    ld(A_ISTAT, C_W, 32'h0, "misalign_w1c");
    @(negedge clk);
    n_checks++;
    if (int_o !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_w1c_int: INT got %b expected 0", int_o);
    end
  endtask

  task automatic test_mmio;
    st(A_LED, 32'h0000_1111, C_W);
    st(A_LED, 32'h0000_BEEF, C_HU);
    @(negedge clk);
    n_checks++;
    if (led_out !== 16'h1111) begin
      n_fail++;
      $display("FAIL led_half_ignored: led_out got %h expected 1111", led_out);
    end
    st(A_LED, 32'h0001_BEEF, C_W);
    ld(A_LED, C_W, 32'h0000_BEEF, "led_word_read");
    @(negedge clk);
    n_checks++;
    if (led_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL led_word: led_out got %h expected beef", led_out);
    end
    ld(A_LED, C_BS, 32'hFFFF_FFEF, "led_byte_s");
    st(A_CYCLE, 32'h0000_0000, C_W);
    ld(A_CYCLE, C_W, 32'(next_cycle), "cycle_store_ignored");
    ld(A_TCMP, C_W, 32'hFFFF_FFFF, "tcmp_read");
    ld(32'hFFFF_0010, C_W, 32'h0, "unmapped_read");
  endtask

  // ---------------- main / report ----------------
  initial begin
    reset       = 1'b1;
    bus.mem_w   = 1'b0;
    bus.Addr_in = '0;
    bus.Data_in = '0;
    bus.dm_ctrl = C_W;
    sb_chk      = 1'b0;
    n_checks    = 0;
    n_fail      = 0;
    next_cycle  = 0;

    test_reset();
    test_ram_lanes();
    test_back_to_back();
    test_timer();
    test_misalign();
    test_mmio();

    cyc(1'b0, 32'h0, 32'h0, C_W, 1'b0, 32'h0, "");
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder end of the single-cycle CPU's data-memory interface.
- Accepts mem_w, address, store data and dm_ctrl from the core; returns load data in the same cycle; commits stores on the clock edge.
- Decodes addresses into a word-organised RAM or a small MMIO register bank: LED output, free-running cycle counter, timer compare, interrupt status.
- Drives the core's INT input from the timer interrupt.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- MMIO_HI, 16'hFFFF: value of Addr_in[31:16] that selects the MMIO bank.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_w  in  1  store strobe from the core.
- Addr_in  in  32  byte address (core ALU output).
- Data_in  in  32  store data (core rs2).
- dm_ctrl  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; others treated as word.
- Data_out  out  32  load data to the core, combinational.
- led_out  out  16  LED register contents.
- INT  out  1  interrupt request to the core.

Behaviour:
- Interface is decided: one clock, clk; reset is synchronous and active-high, named reset.
- Region select:
  - MMIO when Addr_in[31:16]==MMIO_HI; otherwise RAM.
  - RAM index = Addr_in[log2(DEPTH_WORDS)+1:2]; upper bits ignored, so the RAM aliases.
- Loads (combinational, zero latency):
  - Select the addressed word, then the lane by Addr_in[1:0] (byte) or Addr_in[1] (half).
  - Signed types sign-extend to 32 bits; unsigned types zero-extend.
- Alignment:
  - Misaligned accesses are a word with Addr_in[1:0]!=0, or a half with Addr_in[0]=1.
  - Misaligned load: Data_out=0.
  - Misaligned store: ignored.
- Stores (RAM): on a rising edge with mem_w=1, write only the addressed lanes (4/2/1 byte enables). Other bytes are unchanged.
- MMIO map (offset = Addr_in[15:0]; other offsets read 0, writes ignored):
  - 0x0 LED: RW, bits[15:0]; reads zero-extended.
  - 0x4 CYCLE: RO 32-bit counter; +1 every cycle; wraps FFFFFFFF->0; writes ignored.
  - 0x8 TCMP: RW 32-bit compare value.
  - 0xC ISTAT: bit0 timer-pending (W1C); bit1 per the optional feature; other bits read 0.
- MMIO stores: only word stores take effect; sub-word stores to MMIO are ignored. Sub-word loads extract lanes as in RAM.
- Timer pending:
  - Set in the cycle after CYCLE==TCMP, i.e. a registered compare.
  - Cleared by a word store to ISTAT with Data_in[0]=1.
  - A set and a clear in the same cycle: set wins.
- INT = ISTAT bit0 (| bit1 when the optional feature is enabled). Registered; no combinational path from the inputs.
- Reset (synchronous):
  - LED=0, CYCLE=0, TCMP=32'hFFFFFFFF, ISTAT=0, INT=0.
  - RAM contents are not reset.
  - Reset has priority over any store in the same cycle.
  - Reset mid-run discards pending interrupts.
- A store and a load to the same address in the same cycle: Data_out shows the old value; the new value is visible the next cycle.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Enabled:
  - Any misaligned access (load, or store with mem_w) sets ISTAT bit1 on the next edge.
  - Bit1 is W1C with Data_in[1]; a set and a clear in the same cycle: set wins.
  - Bit1 contributes to INT.
- Disabled: bit1 reads 0; misaligned accesses are silently dropped; INT = bit0 only.

Test Plan:
- Word store 0x12345678 @0x100, then loads:
  - byte signed @0x103 -> 0x00000012.
  - half unsigned @0x102 -> 0x00001234.
  - word -> 0x12345678.
- Byte store 0xAB @0x101 over the word above -> word read 0x1234AB78; byte signed @0x101 -> 0xFFFFFFAB.
- Reset held 1 cycle with mem_w=1 to LED -> led_out=0, CYCLE reads 0 next cycle, then increments by 1 per cycle.
- Write TCMP=20 at reset+0 -> INT rises in the cycle after CYCLE==20. W1C to ISTAT -> INT low next cycle. W1C in the set cycle -> INT stays 1.
- Word store @0x102 -> RAM unchanged, load returns 0. With DMEM_MISALIGN_TRAP_EN: ISTAT reads 0x2, INT=1.
- Half store 0xBEEF to LED offset -> led_out unchanged. Word store 0x0001BEEF -> led_out=0xBEEF. Store to CYCLE ignored.
